// File: rtl/hyperram_ctrl_responder.sv
// Block-RAM stand-in for one HyperRAM controller channel on its user-side command/data interface.
// First read word 5+2*latency cycles after cs (default LAT_BASE); no backpressure, ready low while busy.
module hyperram_ctrl_responder #(
  parameter int ADDR_W     = 10,
  parameter int LAT_BASE   = 4,
  parameter int WR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        ctrl_cs,
  input  logic [1:0]  ctrl_mode,
  input  logic [31:0] ctrl_num_words,
  input  logic [2:0]  ctrl_latency,
  input  logic [31:0] ctrl_addr_in,
  input  logic [31:0] ctrl_wr_data_in,
  input  logic        ctrl_wr_data_valid,
  output logic [31:0] ctrl_rd_data_out,
  output logic        ctrl_rd_data_valid,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LAT,
    S_RD_BURST,
    S_WR_BURST,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rem;
  logic [31:0]       r_lat;
  logic [31:0]       r_idle;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic        w_rd_en;
  logic        w_wr_en;
  logic        w_last_wr;
  logic        w_timeout;
  logic [31:0] w_lat_load;
  logic        w_unused;

  // Loaded one below L so the zero test fires on the edge that emits the first word.
  assign w_lat_load = 32'(LAT_BASE) + {28'd0, ctrl_latency, 1'b0} - 32'd1;
  assign w_unused   = ^{ctrl_mode[1], ctrl_addr_in[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ctrl_cs) begin
          if (ctrl_num_words == 32'd0) begin
            w_next = S_FINISH;
          end else if (ctrl_mode[0]) begin
            w_next = S_RD_LAT;
          end else begin
            w_next = S_WR_BURST;
          end
        end
      end
      S_RD_LAT: begin
        if (r_lat == 32'd0) begin
          w_next = S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        if (r_rem == 32'd0) begin
          w_next = S_FINISH;
        end
      end
      S_WR_BURST: begin
        if (w_last_wr || w_timeout) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (r_state == S_IDLE);
    done      = (r_state == S_FINISH);
    w_wr_en   = (r_state == S_WR_BURST) && ctrl_wr_data_valid;
    w_last_wr = w_wr_en && (r_rem == 32'd1);
    // A valid arriving on the would-be timeout cycle wins over the timeout.
    w_timeout = (r_state == S_WR_BURST) && !ctrl_wr_data_valid &&
                (r_idle == 32'(WR_TIMEOUT - 1));
    w_rd_en   = ((r_state == S_RD_LAT) && (r_lat == 32'd0)) ||
                ((r_state == S_RD_BURST) && (r_rem != 32'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr             <= '0;
      r_rem              <= '0;
      r_lat              <= '0;
      r_idle             <= '0;
      ctrl_rd_data_valid <= 1'b0;
      err                <= 1'b0;
    end else begin
      ctrl_rd_data_valid <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (ctrl_cs) begin
            r_addr <= ctrl_addr_in[ADDR_W-1:0];
            r_rem  <= ctrl_num_words;
            r_lat  <= w_lat_load;
            r_idle <= '0;
          end
        end
        S_RD_LAT, S_RD_BURST: begin
          if (w_rd_en) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 32'd1;
          end else if (r_state == S_RD_LAT) begin
            r_lat <= r_lat - 32'd1;
          end
        end
        S_WR_BURST: begin
          if (w_wr_en) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 32'd1;
            r_idle <= '0;
          end else if (w_timeout) begin
            err <= 1'b1;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= ctrl_wr_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rd_data_out <= '0;
    end else if (w_rd_en) begin
      ctrl_rd_data_out <= r_mem[r_addr];
    end
  end

endmodule

// File: tb/tb_hyperram_ctrl_responder.sv
// Bench for hyperram_ctrl_responder: read words are scoreboarded against a bench-side memory model.
module tb_hyperram_ctrl_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        cs;
  logic [1:0]  mode;
  logic [31:0] nw;
  logic [2:0]  lat;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        wv;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;

  hyperram_ctrl_responder dut (
    .clk               (clk),
    .rst               (rst),
    .ready             (ready),
    .ctrl_cs           (cs),
    .ctrl_mode         (mode),
    .ctrl_num_words    (nw),
    .ctrl_latency      (lat),
    .ctrl_addr_in      (addr),
    .ctrl_wr_data_in   (wd),
    .ctrl_wr_data_valid(wv),
    .ctrl_rd_data_out  (rd_data),
    .ctrl_rd_data_valid(rd_valid),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tot = 0;
  int          n_bad = 0;
  int          t_cs  = 0;
  logic [31:0] sb[$];
  logic [31:0] model [0:1023];

  typedef struct {
    logic [2:0]  lat;
    logic [31:0] addr;
    logic [31:0] n;
    int          exp_dly;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL rd_unexpected: got word %h with nothing pending (cyc %0d)", rd_data, cyc);
      end else begin
        chk("rd_data", rd_data, sb.pop_front());
      end
    end
  end

  task automatic cmd(input logic rd, input logic [31:0] a, input logic [31:0] n, input logic [2:0] l);
    @(negedge clk);
    cs   = 1'b1;
    mode = {1'b1, rd};
    addr = a;
    nw   = n;
    lat  = l;
    t_cs = cyc;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] d, input int gap);
    repeat (gap) @(negedge clk);
    wv = 1'b1;
    wd = d;
    @(negedge clk);
    wv = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] n, input logic [2:0] l,
                         input int exp_dly, input bit poke);
    int nv;
    for (int k = 0; k < int'(n); k++) sb.push_back(model[10'(a + 32'(k))]);
    cmd(1'b1, a, n, l);
    if (poke) begin
      cs   = 1'b1;
      mode = 2'b00;
      addr = 32'h0;
      nw   = 32'd7;
      @(negedge clk);
      cs = 1'b0;
    end
    while (rd_valid !== 1'b1 && cyc - t_cs < 40) @(negedge clk);
    chk("rd_first_dly", 32'(cyc - t_cs), 32'(exp_dly));
    nv = 0;
    while (rd_valid === 1'b1 && nv < int'(n) + 4) begin
      nv++;
      @(negedge clk);
    end
    chk("rd_words", 32'(nv), n);
    chk("rd_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("rd_ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0] = '{3'd0, 32'h10,  32'd4,  5};
    tbl[1] = '{3'd1, 32'h3FE, 32'd3,  7};
    tbl[2] = '{3'd2, 32'h80,  32'd16, 9};
    tbl[3] = '{3'd3, 32'h12,  32'd2,  11};
    tbl[4] = '{3'd4, 32'h3FF, 32'd2,  13};
    tbl[5] = '{3'd5, 32'h85,  32'd1,  15};
    tbl[6] = '{3'd6, 32'h10,  32'd4,  17};
    tbl[7] = '{3'd7, 32'h8A,  32'd6,  19};

    rst = 1'b1; cs = 1'b0; mode = 2'b00; nw = '0; lat = '0; addr = '0; wd = '0; wv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    // Four words with gaps of 0..3 cycles.
    cmd(1'b0, 32'h10, 32'd4, 3'd0);
    chk("wr_ready_low", 32'(ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      wr_word(32'hA0 + 32'(k), k);
      model[10'(32'h10 + 32'(k))] = 32'hA0 + 32'(k);
      if (k < 3) chk("wr_no_early_done", 32'(done), 32'd0);
    end
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_finish_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("wr_done_once", 32'(done), 32'd0);
    chk("wr_ready_after", 32'(ready), 32'd1);
    do_read(32'h10, 32'd4, 3'd0, 5, 1'b0);

    // Address wrap and ignored upper address bits.
    cmd(1'b0, 32'h3FE, 32'd3, 3'd0);
    for (int k = 0; k < 3; k++) begin
      wr_word(32'hB0 + 32'(k), 0);
      model[10'(32'h3FE + 32'(k))] = 32'hB0 + 32'(k);
    end
    chk("wrap_wr_done", 32'(done), 32'd1);
    @(negedge clk);
    do_read(32'h3FE, 32'd3, 3'd0, 5, 1'b0);
    do_read(32'h1003FE, 32'd3, 3'd1, 7, 1'b0);
    do_read(32'h0, 32'd1, 3'd0, 5, 1'b0);

    // Known background at 0x80..0x8F, then an 8-word write followed by 6 stray valids.
    cmd(1'b0, 32'h80, 32'd16, 3'd0);
    for (int k = 0; k < 16; k++) begin
      wr_word(32'hC0 + 32'(k), 0);
      model[10'(32'h80 + 32'(k))] = 32'hC0 + 32'(k);
    end
    chk("fill_done", 32'(done), 32'd1);
    @(negedge clk);
    cmd(1'b0, 32'h80, 32'd8, 3'd0);
    for (int k = 0; k < 8; k++) begin
      wr_word(32'hD0 + 32'(k), k % 2);
      model[10'(32'h80 + 32'(k))] = 32'hD0 + 32'(k);
    end
    chk("wr8_done", 32'(done), 32'd1);
    for (int k = 0; k < 6; k++) wr_word(32'hEE00 + 32'(k), 0);
    chk("extra_ready", 32'(ready), 32'd1);
    do_read(32'h80, 32'd14, 3'd3, 11, 1'b0);

    for (int i = 0; i < 8; i++) do_read(tbl[i].addr, tbl[i].n, tbl[i].lat, tbl[i].exp_dly, 1'b0);

    // Zero-length command.
    cmd(1'b1, 32'h10, 32'd0, 3'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_ready", 32'(ready), 32'd1);

    do_read(32'h10, 32'd4, 3'd2, 9, 1'b1);
    do_read(32'h0, 32'd1, 3'd0, 5, 1'b0);

    // Valid on the exact cycle the idle counter would expire is still accepted.
    cmd(1'b0, 32'h20, 32'd2, 3'd0);
    wr_word(32'h11, 0);
    wr_word(32'h22, 254);
    model[10'h20] = 32'h11;
    model[10'h21] = 32'h22;
    chk("edge_to_done", 32'(done), 32'd1);
    chk("edge_to_err", 32'(err), 32'd0);
    @(negedge clk);
    do_read(32'h20, 32'd2, 3'd0, 5, 1'b0);

    // Genuine timeout.
    cmd(1'b0, 32'h30, 32'd8, 3'd0);
    wr_word(32'h31, 0);
    wr_word(32'h32, 0);
    model[10'h30] = 32'h31;
    model[10'h31] = 32'h32;
    w = 0;
    while (done !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("to_idle_cycles", 32'(w), 32'd255);
    chk("to_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("to_ready", 32'(ready), 32'd1);
    do_read(32'h30, 32'd2, 3'd0, 5, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset five words into a 16-word read.
    for (int k = 0; k < 16; k++) sb.push_back(model[10'(32'h80 + 32'(k))]);
    cmd(1'b1, 32'h80, 32'd16, 3'd0);
    w = 0;
    while (rd_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_data", rd_data, 32'd0);
    do_read(32'h10, 32'd4, 3'd0, 5, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/hyperram_ctrl_responder.md
Name: hyperram_ctrl_responder

Overview:
- Synthesizable stand-in for one HyperRAM controller channel. It responds on the controller's user-side command/data interface (cs, mode, num_words, latency, addr, write stream, read stream).
- Backed by an internal block-RAM word array. Lets the VIO-driven read/write sequencer and board-level test logic be exercised without the HyperRAM chips or the PHY.
- Sits in place of a controller instance in the top level. Single clock domain, no external pins.

Parameters:
- ADDR_W, 10, word-address bits implemented; memory depth = 2**ADDR_W 32-bit words; upper ctrl_addr_in bits ignored.
- LAT_BASE, 4, fixed clk cycles added to every read's initial latency.
- WR_TIMEOUT, 255, max idle clk cycles between write words before a write burst aborts (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ready  out  1  high when IDLE and able to accept ctrl_cs.
- ctrl_cs  in  1  single-cycle command strobe; sampled only when ready=1.
- ctrl_mode  in  2  bit0=1 read, bit0=0 write; bit1 reserved, ignored.
- ctrl_num_words  in  32  burst length in 32-bit words.
- ctrl_latency  in  3  extra read latency code.
- ctrl_addr_in  in  32  starting word address.
- ctrl_wr_data_in  in  32  write word.
- ctrl_wr_data_valid  in  1  write word strobe.
- ctrl_rd_data_out  out  32  read word.
- ctrl_rd_data_valid  out  1  read word strobe, one cycle per word.
- done  out  1  one-cycle pulse when a burst completes or aborts.
- err  out  1  sticky; set on write timeout; cleared only by rst.

Behaviour:
- Reset (synchronous, at any time including mid-burst):
  - state=IDLE, ready=1, ctrl_rd_data_valid=0, ctrl_rd_data_out=0, done=0, err=0, all counters 0.
  - Memory contents are not cleared.
- States: IDLE, RD_LAT, RD_BURST, WR_BURST, FINISH.
- IDLE:
  - ready=1.
  - ctrl_cs=1 at edge T registers addr[ADDR_W-1:0], num_words, latency and mode.
  - If num_words==0: go to FINISH. No data moves; done pulses in cycle T+1.
  - Else if mode[0]=1: go to RD_LAT. Else go to WR_BURST.
  - ready drops to 0 in cycle T+1.
- ctrl_cs while ready=0 is ignored; there is no queuing.
- RD_LAT:
  - A counter loads L = LAT_BASE + 2*latency (range 4..18 with defaults).
  - The first ctrl_rd_data_valid is high in cycle T+L+1, carrying mem[addr].
- RD_BURST:
  - One word per cycle, back-to-back, no gaps, num_words words.
  - Word k = mem[(addr+k) mod 2**ADDR_W]; the address wraps silently.
  - A synchronous BRAM read is prefetched during RD_LAT so there are no bubbles.
  - ctrl_rd_data_out holds the last word after valid drops.
  - Go to FINISH the cycle after the last valid.
- WR_BURST:
  - Accepts ctrl_wr_data_valid from cycle T+1 onward.
  - Each valid word is written to (addr+count) mod depth; count increments.
  - When count reaches num_words, go to FINISH. Any further valids are ignored (not written).
  - An idle counter resets on each valid and increments otherwise. When it reaches WR_TIMEOUT: set err=1, go to FINISH. Words already written are retained.
- FINISH:
  - done=1 for exactly one cycle, ready stays 0.
  - Next cycle: IDLE, ready=1.
  - Minimum cs-to-cs spacing is therefore burst + 2 cycles.
- Widths:
  - Burst counters are 32-bit; a num_words of 2**32-1 is legal and simply wraps the address many times.
  - The latency arithmetic is sized so there is no overflow.
- Simultaneous events:
  - rst wins over everything.
  - In WR_BURST, a valid on the same cycle the idle counter would hit WR_TIMEOUT is accepted and resets the idle counter.
- Read-after-write is coherent: a read issued after a write's done pulse returns the written data.

Test Plan:
- Reset, then IDLE: ready=1, rd_valid=0, done=0, err=0. Assert rst during RD_BURST of 16 words after 5 words: next cycle rd_valid=0, ready=1.
- Write burst: cs with mode=0, addr=0x10, num_words=4, then valid words 0xA0..0xA3 with gaps of 0–3 cycles -> done once after the 4th word, ready high the next cycle. Read back: mode=1, latency=0 -> first valid exactly 5 cycles after cs, data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
- Latency sweep: latency 0..7 -> first rd_valid at cycle T+5+2*latency; words are contiguous; valid is asserted for exactly num_words cycles.
- Wrap: write 3 words to addr 0x3FE (ADDR_W=10) -> words land at 0x3FE, 0x3FF, 0x000. Read 3 from 0x3FE returns them in order. Bits above ADDR_W in addr are ignored: addr 0x1003FE gives the same result.
- Write timeout: num_words=8, send 2 words, then stall 255 cycles -> err=1, done pulse, ready=1. Those 2 words are readable; err stays set across subsequent bursts until rst.
- Edge commands:
  - num_words=0 -> done in T+1, no rd_valid.
  - cs pulsed mid-read -> ignored, and the burst is unchanged.
  - 6 extra wr_valid words after an 8-word write completes -> not written; memory is unchanged.
